branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The module SHALL have a parameter FLUSH_CYCLES, default 2 (range 1-15), giving the number of cycles flush is held after a redirect.
REQ-002 The module SHALL have a parameter CNT_W, default 16, giving the width of the statistics counters.
REQ-003 The module SHALL have the following ports, one clock and a synchronous active-high reset:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- br_valid  in  1  decode offers a control-transfer op.
- br_ready  out  1  resolver accepts the op.
- br_f3  in  3  branch funct3.
- br_jal  in  1  op is JAL.
- br_jalr  in  1  op is JALR.
- br_pc  in  32  PC of the op.
- br_imm  in  32  sign-extended immediate.
- br_rs1  in  32  operand 1.
- br_rs2  in  32  operand 2.
- cmp_rs1  out  32  operand 1 driven to the shared comparator.
- cmp_rs2  out  32  operand 2 driven to the shared comparator.
- cmp_f3  out  3  funct3 driven to the shared comparator.
- cmp_taken  in  1  combinational comparator result.
- redir_valid  out  1  redirect request to fetch.
- redir_ready  in  1  fetch accepts the redirect.
- redir_pc  out  32  redirect target.
- link_pc  out  32  br_pc+4 of the resolved op, valid with redir_valid.
- flush  out  1  kill younger instructions.
- misalign  out  1  one-cycle pulse; target[1:0]!=0.
- br_cnt  out  CNT_W  resolved ops count.
- taken_cnt  out  CNT_W  taken/redirected ops count.

Function
REQ-004 The FSM SHALL have states IDLE, EVAL, REDIR, FLUSH; br_ready SHALL be 1 only in IDLE.
REQ-005 In IDLE, br_valid&br_ready SHALL latch f3, jal, jalr, pc, imm, rs1, rs2 and move to EVAL next cycle.
REQ-006 In EVAL, cmp_rs1/cmp_rs2/cmp_f3 SHALL present the latched operands; in all other states they SHALL hold their last values, which are 0 after reset.
REQ-007 In EVAL, taken = jal | jalr | cmp_taken; JAL/JALR SHALL ignore cmp_taken.
REQ-008 The target SHALL be pc+imm for branches and JAL, and (rs1+imm)&~1 for JALR, computed mod 2^32 with wrap-around allowed.
REQ-009 In EVAL, when taken and target[1:0]!=0, misalign SHALL pulse for one cycle, no redirect or flush SHALL occur, and the FSM SHALL go to IDLE.
REQ-010 In EVAL, when not taken, the FSM SHALL go to IDLE with no redirect or flush.
REQ-011 In EVAL, when taken and the target is aligned, the FSM SHALL go to REDIR.
REQ-012 In REDIR, redir_valid SHALL be 1 and redir_pc/link_pc SHALL remain stable until redir_ready.
REQ-013 On redir_valid&redir_ready, the FSM SHALL move to FLUSH the next cycle.
REQ-014 flush SHALL be 1 in REDIR and for exactly FLUSH_CYCLES cycles in FLUSH, then the FSM SHALL return to IDLE.
REQ-015 A down-counter SHALL time the FLUSH state; it SHALL load FLUSH_CYCLES-1 on entry.
REQ-016 br_cnt SHALL increment once per op leaving EVAL; taken_cnt SHALL increment once per op entering REDIR.
REQ-017 Both counters SHALL saturate at all-ones and not wrap.
REQ-018 Minimum throughput SHALL be one not-taken op every 2 cycles, and one taken op every 3+FLUSH_CYCLES cycles when redir_ready is held at 1.
REQ-019 br_f3 values 010 and 011 with neither jal nor jalr set SHALL be treated as not taken, whatever cmp_taken is.

Reset
REQ-020 On rst=1 at a clock edge, the FSM SHALL go to IDLE, overriding any state including mid-REDIR or mid-FLUSH.
REQ-021 On reset, all outputs SHALL be 0 except br_ready, which SHALL be 1 in the cycle after reset.
REQ-022 On reset, any in-flight op SHALL be discarded without a counter update.
REQ-023 While rst=1, br_ready SHALL be 0.

Verification
REQ-024 The bench SHALL cover BEQ, rs1=rs2=5, pc=0x100, imm=0x20, cmp_taken=1, redir_ready=1 -> redir_pc=0x120, link_pc=0x104, flush high 3 cycles total, br_cnt=1, taken_cnt=1.
REQ-025 The bench SHALL cover BNE, rs1=rs2, cmp_taken=0 -> no redir_valid, no flush, br_ready back 2 cycles after acceptance.
REQ-026 The bench SHALL cover JALR, rs1=0x1003, imm=0 -> redir_pc=0x1002 and misalign pulses, with no redirect.
REQ-027 The bench SHALL cover redir_ready held 0 for 5 cycles -> redir_valid and redir_pc stable for 6 cycles, then flush.
REQ-028 The bench SHALL cover rst asserted in the second FLUSH cycle -> flush=0 next cycle, IDLE, counters=0.
REQ-029 The bench SHALL cover CNT_W=4 with 20 taken JALs -> br_cnt=taken_cnt=15.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch/jump resolver: evaluates one control-transfer op at a time,
// issues the fetch redirect, and holds flush while the pipeline drains.
module branch_resolver #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_f3,
  input  logic             br_jal,
  input  logic             br_jalr,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_imm,
  input  logic [31:0]      br_rs1,
  input  logic [31:0]      br_rs2,
  output logic [31:0]      cmp_rs1,
  output logic [31:0]      cmp_rs2,
  output logic [2:0]       cmp_f3,
  input  logic             cmp_taken,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [31:0]      redir_pc,
  output logic [31:0]      link_pc,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    REDIR,
    FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [2:0]       f3_q, f3_d;
  logic             jal_q, jal_d;
  logic             jalr_q, jalr_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      imm_q, imm_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic [31:0]      link_pc_q, link_pc_d;
  logic             redir_valid_q, redir_valid_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic             is_slt;
  logic             taken;
  logic [31:0]      target;

  assign br_ready    = (state_q == IDLE) && !rst;
  assign cmp_rs1     = rs1_q;
  assign cmp_rs2     = rs2_q;
  assign cmp_f3      = f3_q;
  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign link_pc     = link_pc_q;
  assign flush       = flush_q;
  assign misalign    = misalign_q;
  assign br_cnt      = br_cnt_q;
  assign taken_cnt   = taken_cnt_q;

  // Resolve decision and target from the latched op.
  always_comb begin
    is_slt = (f3_q == 3'b010) || (f3_q == 3'b011);
    taken  = jal_q || jalr_q || (cmp_taken && !is_slt);
    if (jalr_q) begin
      target = (rs1_q + imm_q) & ~32'd1;
    end else begin
      target = pc_q + imm_q;
    end
  end

  // Next-state and registered-output logic for the resolver FSM.
  always_comb begin
    state_d       = state_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    f3_d          = f3_q;
    jal_d         = jal_q;
    jalr_d        = jalr_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    redir_pc_d    = redir_pc_q;
    link_pc_d     = link_pc_q;
    redir_valid_d = redir_valid_q;
    flush_d       = flush_q;
    misalign_d    = 1'b0;
    fcnt_d        = fcnt_q;
    br_cnt_d      = br_cnt_q;
    taken_cnt_d   = taken_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (br_valid && br_ready) begin
          rs1_d   = br_rs1;
          rs2_d   = br_rs2;
          f3_d    = br_f3;
          jal_d   = br_jal;
          jalr_d  = br_jalr;
          pc_d    = br_pc;
          imm_d   = br_imm;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (br_cnt_q != '1) begin
          br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        state_d = IDLE;
        if (taken) begin
          redir_pc_d = target;
          link_pc_d  = pc_q + 32'd4;
          if (target[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end else begin
            state_d       = REDIR;
            redir_valid_d = 1'b1;
            flush_d       = 1'b1;
            if (taken_cnt_q != '1) begin
              taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      REDIR: begin
        if (redir_ready) begin
          state_d       = FLUSH;
          redir_valid_d = 1'b0;
          fcnt_d        = 4'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fcnt_q == 4'd0) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
    endcase
  end

  // State register; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rs1_q         <= '0;
      rs2_q         <= '0;
      f3_q          <= '0;
      jal_q         <= 1'b0;
      jalr_q        <= 1'b0;
      pc_q          <= '0;
      imm_q         <= '0;
      redir_pc_q    <= '0;
      link_pc_q     <= '0;
      redir_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      fcnt_q        <= '0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      f3_q          <= f3_d;
      jal_q         <= jal_d;
      jalr_q        <= jalr_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      redir_pc_q    <= redir_pc_d;
      link_pc_q     <= link_pc_d;
      redir_valid_q <= redir_valid_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      fcnt_q        <= fcnt_d;
      br_cnt_q      <= br_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: vector table, random ops against a
// transaction-level model, and reset/saturation sequences.
module tb_branch_resolver;

  localparam int F = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [2:0]  br_f3;
  logic        br_jal;
  logic        br_jalr;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic [31:0] br_rs1;
  logic [31:0] br_rs2;
  logic        cmp_taken;
  logic        redir_ready;

  logic        br_ready, redir_valid, flush, misalign;
  logic [31:0] cmp_rs1, cmp_rs2, redir_pc, link_pc;
  logic [2:0]  cmp_f3;
  logic [15:0] br_cnt, taken_cnt;

  logic        br_ready4, redir_valid4, flush4, misalign4;
  logic [31:0] cmp_rs14, cmp_rs24, redir_pc4, link_pc4;
  logic [2:0]  cmp_f34;
  logic [3:0]  br_cnt4, taken_cnt4;

  int nvec = 0;
  int nerr = 0;
  int m_br = 0;
  int m_tk = 0;

  always #5 clk = ~clk;

  branch_resolver #(.FLUSH_CYCLES(F), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_ready(br_ready),
    .br_f3(br_f3), .br_jal(br_jal), .br_jalr(br_jalr),
    .br_pc(br_pc), .br_imm(br_imm),
    .br_rs1(br_rs1), .br_rs2(br_rs2),
    .cmp_rs1(cmp_rs1), .cmp_rs2(cmp_rs2), .cmp_f3(cmp_f3),
    .cmp_taken(cmp_taken),
    .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_pc(redir_pc), .link_pc(link_pc),
    .flush(flush), .misalign(misalign),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  branch_resolver #(.FLUSH_CYCLES(F), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_ready(br_ready4),
    .br_f3(br_f3), .br_jal(br_jal), .br_jalr(br_jalr),
    .br_pc(br_pc), .br_imm(br_imm),
    .br_rs1(br_rs1), .br_rs2(br_rs2),
    .cmp_rs1(cmp_rs14), .cmp_rs2(cmp_rs24), .cmp_f3(cmp_f34),
    .cmp_taken(cmp_taken),
    .redir_valid(redir_valid4), .redir_ready(redir_ready),
    .redir_pc(redir_pc4), .link_pc(link_pc4),
    .flush(flush4), .misalign(misalign4),
    .br_cnt(br_cnt4), .taken_cnt(taken_cnt4)
  );

  // External comparator; reports 1 for 010/011 so the resolver must mask it.
  function automatic logic cmp_hw(input logic [2:0] f,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b1;
    endcase
  endfunction

  assign cmp_taken = cmp_hw(cmp_f3, cmp_rs1, cmp_rs2);

  typedef struct {
    logic [2:0]  f3;
    logic        jal;
    logic        jalr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          stall;
    logic        e_taken;
    logic        e_mis;
    logic [31:0] e_tgt;
  } vec_t;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt();
    chk("br_cnt", 64'(br_cnt), 64'(sat(m_br, 65535)));
    chk("taken_cnt", 64'(taken_cnt), 64'(sat(m_tk, 65535)));
    chk("br_cnt4", 64'(br_cnt4), 64'(sat(m_br, 15)));
    chk("taken_cnt4", 64'(taken_cnt4), 64'(sat(m_tk, 15)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    br_valid = 1'b0;
    redir_ready = 1'b1;
    step();
    step();
    chk("rst_br_ready", 64'(br_ready), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_redir_valid", 64'(redir_valid), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_redir_pc", 64'(redir_pc), 64'd0);
    chk("rst_link_pc", 64'(link_pc), 64'd0);
    chk("rst_cmp", {cmp_rs1, cmp_rs2} | 64'(cmp_f3), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(br_ready), 64'd1);
    m_br = 0;
    m_tk = 0;
    chk_cnt();
  endtask

  task automatic run_op(input vec_t v);
    int w;
    w = 0;
    while (!br_ready && w < 20) begin
      step();
      w++;
    end
    if (!br_ready) chk("ready_timeout", 64'd0, 64'd1);
    br_valid = 1'b1;
    br_f3 = v.f3;
    br_jal = v.jal;
    br_jalr = v.jalr;
    br_pc = v.pc;
    br_imm = v.imm;
    br_rs1 = v.rs1;
    br_rs2 = v.rs2;
    step();
    br_valid = 1'b0;
    br_rs1 = $urandom;
    br_rs2 = $urandom;
    chk("eval_cmp_rs1", 64'(cmp_rs1), 64'(v.rs1));
    chk("eval_cmp_rs2", 64'(cmp_rs2), 64'(v.rs2));
    chk("eval_cmp_f3", 64'(cmp_f3), 64'(v.f3));
    chk("eval_ready", 64'(br_ready), 64'd0);
    chk("eval_misalign", 64'(misalign), 64'd0);
    redir_ready = (v.stall == 0);
    step();
    m_br++;
    if (!v.e_taken) begin
      chk("nt_ready", 64'(br_ready), 64'd1);
      chk("nt_redir", {redir_valid, flush, misalign}, 64'd0);
    end else if (v.e_mis) begin
      chk("mis_pulse", 64'(misalign), 64'd1);
      chk("mis_tgt", 64'(redir_pc), 64'(v.e_tgt));
      chk("mis_noredir", {redir_valid, flush}, 64'd0);
      chk("mis_ready", 64'(br_ready), 64'd1);
    end else begin
      m_tk++;
      chk("rd_valid", 64'(redir_valid), 64'd1);
      chk("rd_flush", 64'(flush), 64'd1);
      chk("rd_pc", 64'(redir_pc), 64'(v.e_tgt));
      chk("rd_link", 64'(link_pc), 64'(v.pc + 32'd4));
      for (int i = 0; i < v.stall; i++) begin
        step();
        if (i == v.stall - 1) redir_ready = 1'b1;
        chk("stall_valid", {redir_valid, flush}, 64'h3);
        chk("stall_pc", 64'(redir_pc), 64'(v.e_tgt));
        chk("stall_link", 64'(link_pc), 64'(v.pc + 32'd4));
      end
      for (int j = 0; j < F; j++) begin
        step();
        chk("fl_flush", 64'(flush), 64'd1);
        chk("fl_novalid", {redir_valid, br_ready}, 64'd0);
      end
      step();
      chk("fl_done", {flush, br_ready}, 64'h1);
    end
    chk("lockstep",
        64'({br_ready, redir_valid, flush, misalign, redir_pc, link_pc,
             cmp_rs1, cmp_rs2, cmp_f3} ==
            {br_ready4, redir_valid4, flush4, misalign4, redir_pc4,
             link_pc4, cmp_rs14, cmp_rs24, cmp_f34}),
        64'd1);
    chk_cnt();
    redir_ready = 1'b1;
  endtask

  function automatic vec_t ref_op(input vec_t v);
    vec_t r;
    logic b;
    r = v;
    case (v.f3)
      3'd0:    b = v.rs1 == v.rs2;
      3'd1:    b = v.rs1 != v.rs2;
      3'd4:    b = $signed(v.rs1) < $signed(v.rs2);
      3'd5:    b = $signed(v.rs1) >= $signed(v.rs2);
      3'd6:    b = v.rs1 < v.rs2;
      3'd7:    b = v.rs1 >= v.rs2;
      default: b = 1'b0;
    endcase
    r.e_taken = v.jal || v.jalr || b;
    if (v.jalr) r.e_tgt = (v.rs1 + v.imm) & 32'hFFFF_FFFE;
    else r.e_tgt = v.pc + v.imm;
    r.e_mis = r.e_taken && (r.e_tgt % 4 != 0);
    return r;
  endfunction

  vec_t tbl[13];

  initial begin
    vec_t v;
    br_f3 = '0; br_jal = 0; br_jalr = 0;
    br_pc = '0; br_imm = '0; br_rs1 = '0; br_rs2 = '0;
    //        f3    jal jalr pc            imm           rs1           rs2           st tk mis tgt
    tbl[0]  = '{3'd0, 0, 0, 32'h100,       32'h20,       32'd5,        32'd5,        0, 1, 0, 32'h120};
    tbl[1]  = '{3'd1, 0, 0, 32'h200,       32'h40,       32'd7,        32'd7,        0, 0, 0, 32'h240};
    tbl[2]  = '{3'd0, 0, 1, 32'h80,        32'h0,        32'h1003,     32'd0,        0, 1, 1, 32'h1002};
    tbl[3]  = '{3'd0, 0, 0, 32'h300,       32'h10,       32'd9,        32'd9,        5, 1, 0, 32'h310};
    tbl[4]  = '{3'd0, 1, 0, 32'h400,       32'hFFFF_FFF0, 32'd1,       32'd2,        1, 1, 0, 32'h3F0};
    tbl[5]  = '{3'd4, 0, 0, 32'h500,       32'h8,        32'hFFFF_FFFF, 32'd1,       0, 1, 0, 32'h508};
    tbl[6]  = '{3'd6, 0, 0, 32'h500,       32'h8,        32'hFFFF_FFFF, 32'd1,       0, 0, 0, 32'h508};
    tbl[7]  = '{3'd2, 0, 0, 32'h540,       32'h8,        32'd0,        32'd0,        0, 0, 0, 32'h548};
    tbl[8]  = '{3'd3, 0, 0, 32'h580,       32'h8,        32'd0,        32'd0,        0, 0, 0, 32'h588};
    tbl[9]  = '{3'd0, 1, 0, 32'hFFFF_FFF0, 32'h20,       32'd0,        32'd0,        2, 1, 0, 32'h10};
    tbl[10] = '{3'd0, 0, 1, 32'h600,       32'h3,        32'h2001,     32'd0,        0, 1, 0, 32'h2004};
    tbl[11] = '{3'd5, 0, 0, 32'h700,       32'h6,        32'd1,        32'hFFFF_FFFF, 0, 1, 1, 32'h706};
    tbl[12] = '{3'd7, 0, 0, 32'h700,       32'h6,        32'd1,        32'hFFFF_FFFF, 0, 0, 0, 32'h706};

    do_reset();
    foreach (tbl[i]) run_op(tbl[i]);

    for (int n = 0; n < 150; n++) begin
      int k;
      k = $urandom_range(0, 3);
      v.f3 = 3'($urandom_range(0, 7));
      v.jal = (k == 2);
      v.jalr = (k == 3);
      v.pc = $urandom & 32'hFFFF_FFFC;
      v.imm = ($urandom_range(0, 3) == 0) ? $urandom
                                          : ($urandom & 32'hFFFF_FFFC);
      v.rs1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8))
                                          : $urandom;
      v.rs2 = ($urandom_range(0, 2) == 0) ? v.rs1 : $urandom;
      v.stall = $urandom_range(0, 3);
      v = ref_op(v);
      run_op(v);
    end

    // Reset in the second flush cycle kills the op and clears counters.
    br_valid = 1'b1;
    br_f3 = 3'd0; br_jal = 0; br_jalr = 0;
    br_pc = 32'h800; br_imm = 32'h8; br_rs1 = 32'd3; br_rs2 = 32'd3;
    redir_ready = 1'b1;
    step();
    br_valid = 1'b0;
    step();
    chk("rf_redir", 64'(redir_valid), 64'd1);
    step();
    chk("rf_fl1", 64'(flush), 64'd1);
    step();
    chk("rf_fl2", 64'(flush), 64'd1);
    rst = 1'b1;
    step();
    chk("rf_flush_off", 64'(flush), 64'd0);
    chk("rf_ready_in_rst", 64'(br_ready), 64'd0);
    chk("rf_cnt", {32'(br_cnt), 32'(taken_cnt)}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rf_idle", 64'(br_ready), 64'd1);
    m_br = 0;
    m_tk = 0;
    chk_cnt();

    // Twenty taken JALs saturate the narrow counters.
    do_reset();
    for (int n = 0; n < 20; n++) begin
      v = '{3'd0, 1'b1, 1'b0, 32'h1000 + 32'(n * 16), 32'h40,
            32'd0, 32'd0, 0, 1'b0, 1'b0, 32'd0};
      v = ref_op(v);
      run_op(v);
    end
    chk("sat_br4", 64'(br_cnt4), 64'd15);
    chk("sat_tk4", 64'(taken_cnt4), 64'd15);
    chk("sat_br16", 64'(br_cnt), 64'd20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
